// File: rtl/core_keytone.sv
// Polyphonic one-octave square-wave tone generator.
// Mixes all sounding notes into a single PWM audio bit.
module core_keytone #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int PWM_STEPS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keystroke,
  output logic [11:0] tone,
  output logic [3:0]  voices,
  output logic [3:0]  mix,
  output logic        audio
);

  localparam int FREQ [12] = '{262, 277, 294, 311, 330, 349,
                               370, 392, 415, 440, 466, 494};
  // C4 is the lowest note, so it sets the widest counter
  localparam int HMAX = CLK_FREQ / (2 * 262);
  localparam int CW   = (HMAX > 2) ? $clog2(HMAX) : 1;
  localparam int PW   = (PWM_STEPS > 2) ? $clog2(PWM_STEPS) : 1;
  localparam int MW   = (PW > 4) ? PW : 4;

  function automatic logic [3:0] popcount(input logic [11:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  logic [11:0]   key_m;
  logic [11:0]   key_s;
  logic [CW-1:0] cnt [12];
  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_m <= '0;
      key_s <= '0;
    end else begin
      key_m <= keystroke;
      key_s <= key_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) cnt[i] <= '0;
      tone <= '0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (!key_s[i]) begin
          cnt[i]  <= '0;
          tone[i] <= 1'b0;
        end else if (cnt[i] ==
                     CW'(CLK_FREQ / (2 * FREQ[i]) - 1)) begin
          cnt[i]  <= '0;
          tone[i] <= ~tone[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voices <= '0;
      mix    <= '0;
    end else begin
      voices <= popcount(key_s);
      mix    <= popcount(tone);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= '0;
      audio <= 1'b0;
    end else begin
      if (pcnt == PW'(PWM_STEPS - 1)) pcnt <= '0;
      else pcnt <= pcnt + 1'b1;
      audio <= (MW'(pcnt) < MW'(mix));
    end
  end

endmodule

// File: tb/tb_core_keytone.sv
// Self-checking bench for core_keytone.
// Uses a scaled clock frequency so every note period is short.
module tb_core_keytone;

  localparam int CF = 100_000;
  localparam int PS = 12;
  localparam int FQ [12] = '{262, 277, 294, 311, 330, 349,
                             370, 392, 415, 440, 466, 494};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] keystroke = '0;
  logic [11:0] tone;
  logic [3:0]  voices;
  logic [3:0]  mix;
  logic        audio;

  core_keytone #(.CLK_FREQ(CF), .PWM_STEPS(PS)) dut (
    .clk(clk), .rst(rst), .keystroke(keystroke),
    .tone(tone), .voices(voices), .mix(mix), .audio(audio)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int half [12];
  bit chk_on = 1'b0;

  // Reference: a note sounds by elapsed time since key_s rose,
  // tone = floor(elapsed / HALF) is odd.
  logic [11:0] m_s1, m_s2, m_tone;
  int          m_el [12];
  int          m_voices, m_mix, m_pcnt;
  logic        m_audio;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_tone = '0;
      for (int i = 0; i < 12; i++) m_el[i] = 0;
      m_voices = 0; m_mix = 0; m_pcnt = 0; m_audio = 1'b0;
    end else begin
      m_audio  = (m_pcnt < m_mix);
      m_pcnt   = (m_pcnt + 1) % PS;
      m_mix    = $countones(m_tone);
      m_voices = $countones(m_s2);
      for (int i = 0; i < 12; i++) begin
        m_el[i]   = m_s2[i] ? m_el[i] + 1 : 0;
        m_tone[i] = ((m_el[i] / half[i]) % 2) == 1;
      end
      m_s2 = m_s1;
      m_s1 = keystroke;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (tone !== m_tone || voices !== 4'(m_voices) ||
          mix !== 4'(m_mix) || audio !== m_audio) begin
        errors++;
        $display("FAIL model: tone %h/%h voices %0d/%0d mix %0d/%0d audio %b/%b at %0t",
                 tone, m_tone, voices, m_voices, mix, m_mix,
                 audio, m_audio, $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until tone[k] equals lvl; budget expiry returns -1.
  task automatic wait_tone(input int k, input logic lvl,
                           input int budget, output int n);
    n = 0;
    while (tone[k] !== lvl) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        n = -1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [11:0] keys;
    int          hold;
    int          exp_v;
  } vec_t;

  vec_t tbl [8];
  int   n;
  int   ones;

  initial begin
    for (int i = 0; i < 12; i++) half[i] = CF / (2 * FQ[i]);

    tbl[0] = '{12'h000, 20,  0};
    tbl[1] = '{12'h200, 300, 1};
    tbl[2] = '{12'h011, 250, 2};
    tbl[3] = '{12'h022, 250, 2};
    tbl[4] = '{12'h044, 250, 2};
    tbl[5] = '{12'h088, 250, 2};
    tbl[6] = '{12'hFFF, 400, 12};
    tbl[7] = '{12'h555, 300, 6};

    // reset held with every key pressed
    keystroke = 12'hFFF;
    rst = 1'b1;
    step(5);
    check("rst_tone", int'(tone), 0);
    check("rst_voices", int'(voices), 0);
    check("rst_mix", int'(mix), 0);
    check("rst_audio", int'(audio), 0);
    rst = 1'b0;
    chk_on = 1'b1;
    step(2);
    check("rel_voices_e2", int'(voices), 0);
    step(1);
    check("rel_voices_e3", int'(voices), 12);

    for (int v = 0; v < 8; v++) begin
      keystroke = tbl[v].keys;
      step(tbl[v].hold);
      check($sformatf("tbl%0d_voices", v), int'(voices), tbl[v].exp_v);
      check($sformatf("tbl%0d_stray", v),
            int'(tone & ~tbl[v].keys), 0);
    end

    // no keys: audio stays low
    keystroke = '0;
    step(10);
    ones = 0;
    for (int c = 0; c < 2 * PS; c++) begin
      step(1);
      ones += int'(audio);
    end
    check("silent_audio", ones, 0);

    // A4 first half-period and steady toggle
    keystroke = 12'h200;
    wait_tone(9, 1'b1, 1000, n);
    check("a4_first_rise", n, 2 + half[9]);
    wait_tone(9, 1'b0, 1000, n);
    check("a4_period", n, half[9]);
    check("a4_voices", int'(voices), 1);
    check("a4_others", int'(tone & 12'hDFF), 0);

    // release mid-period, then full restart
    wait_tone(9, 1'b1, 1000, n);
    check("a4_rise2", n, half[9]);
    step(50);
    keystroke = 12'h000;
    step(2);
    check("rel_hold_e2", int'(tone[9]), 1);
    step(1);
    check("rel_clear_e3", int'(tone[9]), 0);
    step(20);
    keystroke = 12'h200;
    wait_tone(9, 1'b1, 1000, n);
    check("repress_rise", n, 2 + half[9]);

    // full chord: mix reaches 12, audio then solid high
    keystroke = '0;
    step(5);
    keystroke = 12'hFFF;
    n = 0;
    while (mix !== 4'd12 && n <= 2000) begin
      step(1);
      n++;
    end
    check("mix12_reached", int'(n <= 2000), 1);
    step(1);
    check("mix12_audio_a", int'(audio), 1);
    step(1);
    check("mix12_audio_b", int'(audio), 1);

    // async reset mid-frame while audio is high
    n = 0;
    while (audio !== 1'b1 && n <= 2000) begin
      step(1);
      n++;
    end
    check("audio_high_pre", int'(audio), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_audio", int'(audio), 0);
    check("arst_tone", int'(tone), 0);
    check("arst_mix", int'(mix), 0);
    check("arst_voices", int'(voices), 0);
    step(2);
    rst = 1'b0;
    wait_tone(11, 1'b1, 1000, n);
    check("arst_restart_b4", n, 2 + half[11]);

    // randomized key patterns against the model
    for (int r = 0; r < 40; r++) begin
      keystroke = 12'($urandom) & 12'($urandom);
      step($urandom_range(5, 450));
    end
    keystroke = '0;
    step(10);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
